// File: rtl/global_defs.sv
// global_defs: shared request-path types (op encoding, address width, queue state and entry).
package global_defs;
    localparam int ADDRESS_WIDTH = 16;
    // Widest age the entry view can carry; narrower counters zero-extend into it.
    localparam int ENTRY_AGE_WIDTH = 16;
    typedef enum logic [1:0] {NOP, READ, WRITE, IFETCH} parsed_op_t;
    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} queue_states_t;
    typedef struct packed {
        parsed_op_t opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [ENTRY_AGE_WIDTH-1:0] age;
    } queue_entry_t;
endpackage

// File: rtl/age_counter.sv
// age_counter: saturating age counter with clear and tick; clear wins over tick.
module age_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    output logic [WIDTH-1:0] age
);
    always_ff @(posedge clk)
        if (rst || clear) age <= '0;
        else if (tick && !(&age)) age <= age + WIDTH'(1);
endmodule

// File: rtl/request_queue.sv
// request_queue: FIFO of parsed ops with drop accounting and a debug state machine.
// Define REQUEST_QUEUE_AGE_EN to build per-entry age counters ticked by CPU_clk rising edges.
module request_queue
    import global_defs::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int AGE_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_ready_s,
    input  parsed_op_t                   opcode,
    input  logic [ADDRESS_WIDTH-1:0]     address,
    input  logic                         CPU_clk,
    input  logic                         deq_ready,
    output logic                         head_valid,
    output parsed_op_t                   head_opcode,
    output logic [ADDRESS_WIDTH-1:0]     head_address,
    output logic [AGE_WIDTH-1:0]         head_age,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy,
    output logic                         overflow_s,
    output logic [15:0]                  drop_count,
    output queue_states_t                state
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    parsed_op_t op_mem [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
    logic [AGE_WIDTH-1:0] age_head;
    logic push_req, push, pop, drop;
    queue_entry_t head;

    assign push_req   = op_ready_s && opcode != NOP;
    assign pop        = deq_ready && !empty;
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign full       = state == FULL;
    assign empty      = state == EMPTY;
    assign occupancy  = count;
    assign head_valid = !empty;
    assign overflow_s = drop && !rst;

    always_ff @(posedge clk)
        if (push) begin
            op_mem[wr_ptr]   <= opcode;
            addr_mem[wr_ptr] <= address;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            state      <= EMPTY;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            case (state)
                EMPTY:   if (push) state <= ACTIVE;
                ACTIVE:  if (push && !pop && count == (PW+1)'(QUEUE_DEPTH-1)) state <= FULL;
                         else if (pop && !push && count == (PW+1)'(1)) state <= EMPTY;
                FULL:    if (pop && !push) state <= ACTIVE;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef REQUEST_QUEUE_AGE_EN
    logic cpu_clk_q, tick;
    logic [AGE_WIDTH-1:0] ages [QUEUE_DEPTH];
    always_ff @(posedge clk) cpu_clk_q <= rst ? 1'b0 : CPU_clk;
    assign tick = CPU_clk && !cpu_clk_q;
    for (genvar i = 0; i < QUEUE_DEPTH; i++) begin : g_age
        age_counter #(.WIDTH(AGE_WIDTH)) u_age (
            .clk  (clk),
            .rst  (rst),
            .clear(push && wr_ptr == PW'(i)),
            .tick (tick),
            .age  (ages[i])
        );
    end
    assign age_head = ages[rd_ptr];
`else
    logic unused;
    assign unused   = CPU_clk;
    assign age_head = '0;
`endif

    // An empty queue presents an all-zero entry, which reads as NOP/0/0.
    always_comb begin
        head = '0;
        if (head_valid) begin
            head.opcode  = op_mem[rd_ptr];
            head.address = addr_mem[rd_ptr];
            head.age     = ENTRY_AGE_WIDTH'(age_head);
        end
    end

    assign head_opcode  = head.opcode;
    assign head_address = head.address;
    assign head_age     = AGE_WIDTH'(head.age);
endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_request_queue;
    import global_defs::*;

    logic clk = 1'b0;
    logic rst, op_ready_s, CPU_clk, deq_ready;
    parsed_op_t opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic head_valid, full, empty, overflow_s;
    parsed_op_t head_opcode;
    logic [ADDRESS_WIDTH-1:0] head_address;
    logic [7:0] head_age;
    logic [4:0] occupancy;
    logic [15:0] drop_count;
    queue_states_t state;

    typedef struct packed {
        parsed_op_t op;
        logic [ADDRESS_WIDTH-1:0] addr;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic exp_ovf = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    request_queue dut (
        .clk         (clk),
        .rst         (rst),
        .op_ready_s  (op_ready_s),
        .opcode      (opcode),
        .address     (address),
        .CPU_clk     (CPU_clk),
        .deq_ready   (deq_ready),
        .head_valid  (head_valid),
        .head_opcode (head_opcode),
        .head_address(head_address),
        .head_age    (head_age),
        .full        (full),
        .empty       (empty),
        .occupancy   (occupancy),
        .overflow_s  (overflow_s),
        .drop_count  (drop_count),
        .state       (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mid-cycle monitor: a pop is about to happen, so the head must match the oldest expected entry.
    always @(negedge clk)
        if (!rst) begin
            check("overflow_s", overflow_s, exp_ovf);
            if (deq_ready && head_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got %0h expected no pop", head_address);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_opcode", head_opcode, e.op);
                    check("pop_address", head_address, e.addr);
                end
            end
        end

    task automatic cyc(input logic v, input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] a,
                       input logic d, input logic push_ok, input logic ovf);
        op_ready_s = v;
        opcode     = op;
        address    = a;
        deq_ready  = d;
        exp_ovf    = ovf;
        if (push_ok) exp_q.push_back({op, a});
        @(posedge clk);
        #1;
        op_ready_s = 1'b0;
        opcode     = NOP;
        deq_ready  = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        op_ready_s = 1'b0;
        opcode = NOP;
        address = '0;
        deq_ready = 1'b0;
        CPU_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_head_valid", head_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_state", state, EMPTY);
        check("rst_drop_count", drop_count, 0);
        check("rst_head_opcode", head_opcode, NOP);
        check("rst_head_address", head_address, 0);
        check("rst_head_age", head_age, 0);

        // Three pushes; the first must not bypass to the head in its own cycle.
        op_ready_s = 1'b1;
        opcode = READ;
        address = 16'h100;
        exp_q.push_back({READ, 16'h100});
        #2 check("no_bypass", head_valid, 0);
        @(posedge clk);
        #1;
        op_ready_s = 1'b0;
        opcode = NOP;
        check("first_head_valid", head_valid, 1);
        check("first_head_opcode", head_opcode, READ);
        check("first_head_address", head_address, 16'h100);
        cyc(1, WRITE, 16'h200, 0, 1, 0);
        cyc(1, IFETCH, 16'h300, 0, 1, 0);
        check("three_occupancy", occupancy, 3);
        check("three_state", state, ACTIVE);
        repeat (3) cyc(0, NOP, 0, 1, 0, 0);
        check("three_drained_empty", empty, 1);
        check("three_drained_queue", exp_q.size(), 0);

        // NOP strobe and pop while empty are both ignored.
        cyc(1, NOP, 16'h55, 0, 0, 0);
        cyc(0, NOP, 0, 1, 0, 0);
        check("nop_occupancy", occupancy, 0);
        check("nop_drop_count", drop_count, 0);
        check("nop_empty", empty, 1);

        // Fill, then one op too many is dropped.
        for (int i = 0; i < 16; i++) cyc(1, parsed_op_t'(1 + i % 3), ADDRESS_WIDTH'(16'h10 + i), 0, 1, 0);
        check("fill_full", full, 1);
        check("fill_state", state, FULL);
        check("fill_occupancy", occupancy, 16);
        cyc(1, WRITE, 16'hDEAD, 0, 0, 1);
        check("drop_count_one", drop_count, 1);
        check("drop_occupancy", occupancy, 16);
        check("drop_head_address", head_address, 16'h10);

        // Push with a simultaneous pop while full takes the freed slot.
        cyc(1, READ, 16'hABC, 1, 1, 0);
        check("swap_occupancy", occupancy, 16);
        check("swap_drop_count", drop_count, 1);
        check("swap_full", full, 1);
        repeat (15) cyc(0, NOP, 0, 1, 0, 0);
        check("abc_is_head", head_address, 16'hABC);
        cyc(0, NOP, 0, 1, 0, 0);
        check("swap_drained_state", state, EMPTY);
        check("swap_drained_queue", exp_q.size(), 0);

        // Streaming 40 entries wraps both pointers.
        for (int i = 0; i <= 40; i++) cyc(i < 40, READ, ADDRESS_WIDTH'(i), i > 0, i < 40, 0);
        check("stream_state", state, EMPTY);
        check("stream_occupancy", occupancy, 0);
        check("stream_queue", exp_q.size(), 0);

        // Aging: 5 rising edges, then 300 in total saturates at 255.
        do_reset();
        cyc(1, READ, 16'h77, 0, 1, 0);
        check("age_start", head_age, 0);
        for (int i = 0; i < 10; i++) begin
            CPU_clk = ~CPU_clk;
            cyc(0, NOP, 0, 0, 0, 0);
        end
`ifdef REQUEST_QUEUE_AGE_EN
        check("age_five", head_age, 5);
`else
        check("age_tied_zero", head_age, 0);
`endif
        for (int i = 0; i < 590; i++) begin
            CPU_clk = ~CPU_clk;
            cyc(0, NOP, 0, 0, 0, 0);
        end
`ifdef REQUEST_QUEUE_AGE_EN
        check("age_saturated", head_age, 255);
`else
        check("age_still_zero", head_age, 0);
`endif

        // Reset after the 10th push, with a push and pop presented in the reset cycle.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, WRITE, ADDRESS_WIDTH'(16'h500 + i), 0, 1, 0);
        check("ten_occupancy", occupancy, 10);
        rst = 1'b1;
        op_ready_s = 1'b1;
        opcode = WRITE;
        address = 16'h999;
        deq_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_ready_s = 1'b0;
        opcode = NOP;
        deq_ready = 1'b0;
        check("midrst_empty", empty, 1);
        check("midrst_head_valid", head_valid, 0);
        check("midrst_occupancy", occupancy, 0);
        check("midrst_state", state, EMPTY);
        cyc(0, NOP, 0, 0, 0, 0);
        check("midrst_still_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
